// File: rtl/aq_spsram_1024x16_mstr.sv
// ---------------------------------------------------------------------------
// aq_spsram_1024x16_mstr
//
// Initiator-side controller for the 1024x16 single-port SRAM macro.
// Converts a valid/ready request stream (read/write with per-bit write mask)
// into the macro pin protocol (A, CEN, GWEN, WEN, D, Q) and returns read data
// on a valid/ready response channel. After reset (when INIT_EN=1), or on an
// accepted init_req, it sweeps every word and writes INIT_VAL to it.
//
// Ports:
//   CLK        in   clock, all logic on the rising edge
//   RST        in   synchronous active-high reset
//   init_req   in   pulse: request a re-initialisation sweep (idle RUN only)
//   init_done  out  high while the controller is in RUN
//   req_vld    in   request valid
//   req_rdy    out  request ready
//   req_wr     in   1 = write, 0 = read
//   req_addr   in   word address
//   req_wdata  in   write data
//   req_bmask  in   per-bit write enable, 1 = write this bit
//   rsp_vld    out  read data valid
//   rsp_rdy    in   response ready
//   rsp_rdata  out  read data
//   sram_a     out  macro address
//   sram_cen   out  macro chip enable, active low
//   sram_gwen  out  macro global write enable, active low
//   sram_wen   out  macro per-bit write enable, active low
//   sram_d     out  macro write data
//   sram_q     in   macro read data, valid the cycle after a read access
//
// Read timing: a read fired in cycle t is captured from sram_q at the end of
// cycle t+1 and presented on rsp_vld/rsp_rdata from cycle t+2 onward.
// ---------------------------------------------------------------------------
module aq_spsram_1024x16_mstr #(
    parameter int unsigned            ADDR_WIDTH = 10,
    parameter int unsigned            DATA_WIDTH = 16,
    parameter bit                     INIT_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0]  INIT_VAL   = 16'h0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_bmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ONES = {DATA_WIDTH{1'b1}};
    localparam state_t                ST_RESET  = INIT_EN ? ST_INIT : ST_RUN;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [ADDR_WIDTH-1:0]   init_cnt_r;
    logic [ADDR_WIDTH-1:0]   init_cnt_nxt_s;
    logic                    init_done_r;
    logic                    rd_pend_r;
    logic                    rsp_vld_r;
    logic [DATA_WIDTH-1:0]   rsp_rdata_r;

    logic                    req_rdy_s;
    logic                    fire_s;
    logic                    wr_fire_s;
    logic                    init_acc_s;

    logic [ADDR_WIDTH-1:0]   sram_a_s;
    logic                    sram_cen_s;
    logic                    sram_gwen_s;
    logic [DATA_WIDTH-1:0]   sram_wen_s;
    logic [DATA_WIDTH-1:0]   sram_d_s;

    // Request handshake and init_req acceptance qualifiers.
    always_comb begin
        req_rdy_s  = 1'b0;
        fire_s     = 1'b0;
        wr_fire_s  = 1'b0;
        init_acc_s = 1'b0;
        if (state_r == ST_RUN) begin
            // One outstanding read at most; the same gate applies to writes,
            // which keeps responses strictly in request order.
            req_rdy_s  = !rd_pend_r && (!rsp_vld_r || rsp_rdy);
            fire_s     = req_vld && req_rdy_s;
            wr_fire_s  = fire_s && req_wr;
            // Re-init only from a fully quiet controller; never queued.
            init_acc_s = init_req && !rd_pend_r && !rsp_vld_r && !fire_s;
        end else begin
            req_rdy_s  = 1'b0;
            fire_s     = 1'b0;
            wr_fire_s  = 1'b0;
            init_acc_s = 1'b0;
        end
    end

    // Next-state and sweep counter logic.
    always_comb begin
        state_nxt_s    = state_r;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            ST_INIT: begin
                // Terminal compare on the last address keeps the counter at
                // ADDR_WIDTH bits without ever re-issuing address 0 in a sweep.
                if (init_cnt_r == ADDR_LAST) begin
                    state_nxt_s    = ST_RUN;
                    init_cnt_nxt_s = ADDR_ZERO;
                end else begin
                    state_nxt_s    = ST_INIT;
                    init_cnt_nxt_s = init_cnt_r + ADDR_ONE;
                end
            end
            ST_RUN: begin
                if (init_acc_s) begin
                    state_nxt_s    = ST_INIT;
                    init_cnt_nxt_s = ADDR_ZERO;
                end else begin
                    state_nxt_s    = ST_RUN;
                    init_cnt_nxt_s = init_cnt_r;
                end
            end
            default: begin
                state_nxt_s    = ST_RESET;
                init_cnt_nxt_s = ADDR_ZERO;
            end
        endcase
    end

    // Macro pin multiplexer: sweep writes in INIT, request pass-through in RUN.
    always_comb begin
        sram_a_s    = ADDR_ZERO;
        sram_cen_s  = 1'b1;
        sram_gwen_s = 1'b1;
        sram_wen_s  = DATA_ONES;
        sram_d_s    = DATA_ZERO;
        case (state_r)
            ST_INIT: begin
                sram_a_s    = init_cnt_r;
                sram_cen_s  = 1'b0;
                sram_gwen_s = 1'b0;
                sram_wen_s  = DATA_ZERO;
                sram_d_s    = INIT_VAL;
            end
            ST_RUN: begin
                sram_a_s    = req_addr;
                sram_d_s    = req_wdata;
                sram_cen_s  = !fire_s;
                sram_gwen_s = !wr_fire_s;
                // A zero mask still issues the access; every bit stays masked.
                if (wr_fire_s) begin
                    sram_wen_s = ~req_bmask;
                end else begin
                    sram_wen_s = DATA_ONES;
                end
            end
            default: begin
                sram_a_s    = ADDR_ZERO;
                sram_cen_s  = 1'b1;
                sram_gwen_s = 1'b1;
                sram_wen_s  = DATA_ONES;
                sram_d_s    = DATA_ZERO;
            end
        endcase
    end

    // State, sweep counter and init_done registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= ST_RESET;
            init_cnt_r  <= ADDR_ZERO;
            init_done_r <= !INIT_EN;
        end else begin
            state_r     <= state_nxt_s;
            init_cnt_r  <= init_cnt_nxt_s;
            init_done_r <= (state_nxt_s == ST_RUN);
        end
    end

    // Read pipeline: pending flag, then capture of sram_q into the response.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pend_r   <= 1'b0;
            rsp_vld_r   <= 1'b0;
            rsp_rdata_r <= DATA_ZERO;
        end else begin
            // req_rdy is low while rd_pend is set, so no fire can overlap it.
            rd_pend_r <= fire_s && !req_wr;
            // Capture takes priority over a response handshake in the same edge.
            if (rd_pend_r) begin
                rsp_vld_r   <= 1'b1;
                rsp_rdata_r <= sram_q;
            end else if (rsp_vld_r && rsp_rdy) begin
                rsp_vld_r   <= 1'b0;
                rsp_rdata_r <= rsp_rdata_r;
            end else begin
                rsp_vld_r   <= rsp_vld_r;
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    assign init_done = init_done_r;
    assign req_rdy   = req_rdy_s;
    assign rsp_vld   = rsp_vld_r;
    assign rsp_rdata = rsp_rdata_r;
    assign sram_a    = sram_a_s;
    assign sram_cen  = sram_cen_s;
    assign sram_gwen = sram_gwen_s;
    assign sram_wen  = sram_wen_s;
    assign sram_d    = sram_d_s;

endmodule

// File: doc/aq_spsram_1024x16_mstr.md
Name: aq_spsram_1024x16_mstr

Overview:
Initiator-side controller for the 1024x16 single-port SRAM macro. It converts a valid/ready request stream (read/write, per-bit mask) into the macro's pin protocol: A, active-low CEN, GWEN and per-bit WEN, D and Q. It returns read data on a valid/ready response channel. It also runs an initialisation sweep that writes INIT_VAL to every word after reset or on request.

Parameters:
ADDR_WIDTH, 10, SRAM address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 16, SRAM data width
INIT_EN, 1, 1 = run the init sweep after reset; 0 = go straight to RUN
INIT_VAL, 16'h0000, value written to every word during the sweep

Ports:
CLK  in  1  clock; all logic on posedge
RST  in  1  synchronous, active-high reset
init_req  in  1  pulse; starts a re-init sweep (honoured only when idle in RUN)
init_done  out  1  high while in RUN
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_bmask  in  DATA_WIDTH  per-bit write enable, 1 = write this bit
rsp_vld  out  1  read data valid
rsp_rdy  in  1  response ready
rsp_rdata  out  DATA_WIDTH  read data
sram_a  out  ADDR_WIDTH  to macro A
sram_cen  out  1  to macro CEN, active low
sram_gwen  out  1  to macro GWEN, active low
sram_wen  out  DATA_WIDTH  to macro WEN, active-low per bit
sram_d  out  DATA_WIDTH  to macro D
sram_q  in  DATA_WIDTH  from macro Q; valid the cycle after a read access

Behaviour:
- States: INIT, RUN. RST enters INIT with init_cnt=0 if INIT_EN=1, else RUN. RST overrides everything, including a sweep in progress; the sweep restarts at 0.
- Reset values after the RST edge: rsp_vld=0, rsp_rdata=0, rd_pend=0, init_cnt=0, init_done = !INIT_EN.
- INIT:
  - Each cycle: sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_a=init_cnt, sram_d=INIT_VAL; init_cnt increments.
  - On the cycle init_cnt = 2^ADDR_WIDTH-1, the state goes to RUN next. The sweep lasts exactly 2^ADDR_WIDTH cycles.
  - req_rdy=0 throughout.
- RUN, combinational issue:
  - fire = req_vld & req_rdy.
  - sram_a = req_addr; sram_d = req_wdata.
  - sram_cen = !fire.
  - sram_gwen = !(fire & req_wr).
  - sram_wen = fire&req_wr ? ~req_bmask : all 1.
  - With no fire: CEN=1, GWEN=1, WEN all 1.
- req_rdy = RUN & !rd_pend & (!rsp_vld | rsp_rdy). The same gate applies to reads and writes; this guarantees one outstanding read and in-order behaviour.
- Read pipeline:
  - Read fire at cycle t sets rd_pend=1 at t+1.
  - At the t+1 edge, rsp_rdata <= sram_q, rsp_vld <= 1, rd_pend <= 0.
  - rsp_vld is observed high at t+2. Request-to-response latency = 2 cycles.
- Response hold: rsp_vld and rsp_rdata stay stable until rsp_vld & rsp_rdy. On that handshake rsp_vld clears, unless the rd_pend capture sets it in the same edge (capture wins).
- Throughput: one read every 2 cycles with rsp_rdy held high. Writes can issue back-to-back, one per cycle.
- Write with req_bmask=0: the access is still issued (CEN=0, GWEN=0, WEN all 1), so no bit changes.
- Write immediately after a read (t+1) is blocked by rd_pend. A write in the cycle rsp_vld is held is allowed and does not disturb rsp_rdata.
- init_req:
  - Accepted only in RUN when !rd_pend & !rsp_vld & !fire; otherwise ignored (not queued).
  - On acceptance: next state INIT, init_cnt=0, init_done=0.
  - init_req during INIT is ignored.
- Address wrap: init_cnt is ADDR_WIDTH+1 bits wide, or the terminal compare is done at 2^ADDR_WIDTH-1; the counter must never re-issue address 0 within one sweep.

Test Plan:
- RST 1 cycle, INIT_EN=1, INIT_VAL=16'hA5A5 -> exactly 1024 cycles of CEN=0/GWEN=0 with sram_a 0..1023; init_done rises in cycle 1025; then read addr 1023 -> rsp_rdata=16'hA5A5 two cycles after fire.
- Write addr 10 data 16'h1234 mask 16'hFFFF, then read addr 10 -> rsp_vld two cycles after read fire, rsp_rdata=16'h1234.
- On 16'h0000, write data 16'hFFFF mask 16'h00F0, then read -> 16'h00F0; sram_wen during the write = 16'hFF0F.
- Read with rsp_rdy=0 for 5 cycles -> rsp_vld/rsp_rdata stable, req_rdy=0; a second read is only accepted in the cycle rsp_rdy=1.
- init_req while rsp_vld=1 -> ignored; init_req when idle -> init_done=0 the next cycle, full 1024-cycle sweep, prior data overwritten.
- RST asserted at init_cnt=500 -> sweep restarts at addr 0 and takes the full 1024 cycles.
